// File: rtl/spm_ctrl.sv
// Sequencer for the serial-parallel multiplier core: latches operands, streams the
// multiplier LSB-first into the core and collects the 2*W-bit serial product.
`timescale 1ns/1ps
module spm_ctrl #(
    parameter int unsigned W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W-1:0]     mc,
    input  logic [W-1:0]     mp,
    output logic             busy,
    output logic             done,
    output logic [2*W-1:0]   prod,
    output logic             spm_clr_n,
    output logic [W-1:0]     spm_x,
    output logic             spm_y,
    input  logic             spm_p
);

    localparam int unsigned PW = 2 * W;
    localparam int unsigned KW = $clog2(PW);
    localparam logic [KW-1:0] K_LAST = KW'(PW - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_e;

    state_e          state_q;
    logic [KW-1:0]   k_q;
    logic [KW-1:0]   k_d;
    logic [W-1:0]    mp_q;
    logic [PW-1:0]   prod_q;
    logic [W-1:0]    spm_x_q;
    logic            busy_q;
    logic            done_q;
    logic            clr_n_q;
    logic            spm_y_q;

    assign k_d = k_q + KW'(1);

    // mp_q shifts right with zero fill, so after W bits spm_y naturally reads 0
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            mp_q    <= '0;
            prod_q  <= '0;
            spm_x_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            clr_n_q <= 1'b0;
            spm_y_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q <= S_LOAD;
                        busy_q  <= 1'b1;
                        spm_x_q <= mc;
                        mp_q    <= mp;
                        prod_q  <= '0;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_LOAD: begin
                    state_q <= S_SHIFT;
                    k_q     <= '0;
                    clr_n_q <= 1'b1;
                    spm_y_q <= mp_q[0];
                    mp_q    <= mp_q >> 1;
                end
                S_SHIFT: begin
                    prod_q[k_q] <= spm_p;
                    if (k_q == K_LAST) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        clr_n_q <= 1'b0;
                        spm_y_q <= 1'b0;
                    end else begin
                        k_q     <= k_d;
                        spm_y_q <= mp_q[0];
                        mp_q    <= mp_q >> 1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign prod      = prod_q;
    assign spm_clr_n = clr_n_q;
    assign spm_x     = spm_x_q;
    assign spm_y     = spm_y_q;

endmodule

// File: tb/tb_spm_ctrl.sv
// Bench for spm_ctrl: a behavioural SPM core answers the serial stream; results
// are compared against plain 64-bit multiplication of the accepted operands.
`timescale 1ns/1ps
module tb_spm_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] mc;
    logic [31:0] mp;
    logic        busy;
    logic        done;
    logic [63:0] prod;
    logic        spm_clr_n;
    logic [31:0] spm_x;
    logic        spm_y;
    logic        spm_p;

    int n_checks = 0;
    int n_err    = 0;

    spm_ctrl #(.W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mc        (mc),
        .mp        (mp),
        .busy      (busy),
        .done      (done),
        .prod      (prod),
        .spm_clr_n (spm_clr_n),
        .spm_x     (spm_x),
        .spm_y     (spm_y),
        .spm_p     (spm_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core model: remembers received y bits; product bit k uses y[0..k] only
    logic [63:0] y_hist;
    logic [6:0]  cnt;
    logic [63:0] cur;
    logic [63:0] full;

    always @(posedge clk) begin
        if (!spm_clr_n) begin
            y_hist <= '0;
            cnt    <= '0;
        end else if (cnt < 7'd64) begin
            y_hist[cnt[5:0]] <= spm_y;
            cnt              <= cnt + 7'd1;
        end
    end

    always_comb begin
        cur = y_hist;
        if (cnt < 7'd64) cur[cnt[5:0]] = spm_y;
        full  = 64'(spm_x) * cur;
        spm_p = (cnt < 7'd64) ? full[cnt[5:0]] : 1'b0;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start one multiplication, scramble inputs after acceptance, check timing and result
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input string tag);
        int cyc;
        int nb;
        mc    = a;
        mp    = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        mc    = $urandom;
        mp    = $urandom;
        cyc   = 1;
        nb    = 0;
        while (!done && cyc < 100) begin
            if (busy) nb++;
            tick();
            cyc++;
        end
        check({tag, "_done_cycle"}, 64'(cyc), 64'd66);
        check({tag, "_busy_cycles"}, 64'(nb), 64'd65);
        check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        check({tag, "_prod"}, prod, 64'(a) * 64'(b));
    endtask

    initial begin
        int nd;
        int d1;
        int d2;
        logic [63:0] p1;
        logic [63:0] p2;
        logic [31:0] mc_v;
        logic [31:0] mp_v;
        logic        exp_y;

        rst   = 1'b0;
        start = 1'b1;
        mc    = 32'hDEAD_BEEF;
        mp    = 32'h1234_5678;
        repeat (3) tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_prod", prod, 64'd0);
        check("rst_clr_n", 64'(spm_clr_n), 64'd0);
        check("rst_spm_y", 64'(spm_y), 64'd0);
        check("rst_spm_x", 64'(spm_x), 64'd0);
        start = 1'b0;
        rst   = 1'b1;
        tick();

        // Basic product, then the controller must settle to idle
        run_mul(32'd3, 32'd5, "basic");
        tick();
        check("basic_done_pulse", 64'(done), 64'd0);
        check("basic_idle_busy", 64'(busy), 64'd0);
        check("basic_prod_hold", prod, 64'd15);

        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, "max");
        run_mul(32'd0, 32'h1234_5678, "zero");
        tick();

        // Start during SHIFT is ignored
        mc = 32'd11; mp = 32'd13; start = 1'b1;
        tick();
        start = 1'b0;
        nd = 0; d1 = 0; p1 = '0;
        for (int c = 1; c <= 80; c++) begin
            if (c == 12) begin start = 1'b1; mc = 32'd7; mp = 32'd7; end
            if (c == 13) start = 1'b0;
            if (done) begin nd++; d1 = c; p1 = prod; end
            tick();
        end
        check("busy_start_ndone", 64'(nd), 64'd1);
        check("busy_start_cycle", 64'(d1), 64'd66);
        check("busy_start_prod", p1, 64'd143);

        // Back-to-back with start held through DONE
        mc = 32'h10000; mp = 32'h10000; start = 1'b1;
        tick();
        mc = 32'd2; mp = 32'h8000_0000;
        nd = 0; d1 = 0; d2 = 0; p1 = '0; p2 = '0;
        for (int c = 1; c <= 140; c++) begin
            if (c == 67) begin
                start = 1'b0;
                check("b2b_no_idle", 64'(busy), 64'd1);
            end
            if (done) begin
                nd++;
                if (nd == 1) begin d1 = c; p1 = prod; end
                else begin d2 = c; p2 = prod; end
            end
            tick();
        end
        check("b2b_ndone", 64'(nd), 64'd2);
        check("b2b_first_cycle", 64'(d1), 64'd66);
        check("b2b_second_cycle", 64'(d2), 64'd132);
        check("b2b_first_prod", p1, 64'h1_0000_0000);
        check("b2b_second_prod", p2, 64'h1_0000_0000);

        // Reset at SHIFT k=20 abandons the operation
        mc = 32'd5; mp = 32'd5; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 22; c++) tick();
        rst = 1'b0;
        tick();
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_prod", prod, 64'd0);
        check("mid_rst_clr_n", 64'(spm_clr_n), 64'd0);
        rst = 1'b1;
        nd = 0;
        for (int c = 0; c < 80; c++) begin
            if (done) nd++;
            tick();
        end
        check("mid_rst_no_done", 64'(nd), 64'd0);
        run_mul(32'd9, 32'd9, "after_rst");
        tick();

        // Core drive: serial y stream, clear window and parallel x
        mc_v = $urandom;
        mp_v = 32'hA5;
        mc = mc_v; mp = mp_v; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 66; c++) begin
            check("drive_clr_n", 64'(spm_clr_n), 64'((c >= 2 && c <= 65) ? 1 : 0));
            check("drive_spm_x", 64'(spm_x), 64'(mc_v));
            if (c >= 2 && c <= 65) begin
                exp_y = ((c - 2) < 32) ? mp_v[c - 2] : 1'b0;
                check("drive_spm_y", 64'(spm_y), 64'(exp_y));
            end
            tick();
        end

        // Random operands, issued back-to-back from DONE
        for (int i = 0; i < 8; i++) begin
            run_mul($urandom, $urandom, "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
